// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with valid/ready handshakes.
// Define MULT_EARLY_TERM_EN to stop once the remaining multiplier bits are zero.
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             term;
  logic             prop;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate terms gated by propagate chains
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_op_a,
  input  logic [WIDTH-1:0]   i_op_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   a_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   prod_q;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   acc_nx;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]   cnt_q;
  logic            last;
  logic            skip;
  logic            cout_unused;

  carry_lookahead_adder #(
    .WIDTH(PW)
  ) u_cla (
    .a   (acc_q),
    .b   (a_q),
    .cin (1'b0),
    .sum (sum),
    .cout(cout_unused)
  );

  assign acc_nx = b_q[0] ? sum : acc_q;

`ifdef MULT_EARLY_TERM_EN
  assign last = (b_q[WIDTH-1:1] == '0) || (cnt_q == CW'(WIDTH - 1));
  assign skip = (i_op_b == '0);
`else
  assign last = (cnt_q == CW'(WIDTH - 1));
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = skip ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_valid) begin
        a_q   <= PW'(i_op_a);
        b_q   <= i_op_b;
        acc_q <= '0;
        cnt_q <= '0;
        if (skip) prod_q <= '0;
      end else if (state == RUN) begin
        acc_q <= acc_nx;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        if (last) prod_q <= acc_nx;
      end
    end
  end

  assign o_product = prod_q;
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_valid, input, 1, operands present.
REQ-005 SHALL have port o_ready, output, 1, block can accept operands.
REQ-006 SHALL have port i_op_a, input, WIDTH, unsigned multiplicand.
REQ-007 SHALL have port i_op_b, input, WIDTH, unsigned multiplier.
REQ-008 SHALL have port o_valid, output, 1, product available.
REQ-009 SHALL have port i_ready, input, 1, consumer takes product.
REQ-010 SHALL have port o_product, output, 2*WIDTH, unsigned product.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL drive o_ready=1 only in IDLE and o_valid=1 only in DONE.
REQ-013 SHALL accept on a rising edge where state is IDLE and i_valid=1: latch A=i_op_a zero-extended to 2*WIDTH, latch B=i_op_b, clear accumulator and step counter, go to RUN.
REQ-014 SHALL, in each RUN cycle: if B[0]=1, accumulator <= accumulator + A; then A <= A<<1, B <= B>>1, counter++.
REQ-015 SHALL perform the accumulate with an instance of carry_lookahead_adder (WIDTH=2*WIDTH, cin=0); its cout SHALL be ignored, because the product cannot exceed 2*WIDTH bits.
REQ-016 SHALL leave RUN for DONE after exactly WIDTH RUN cycles (baseline).
REQ-017 SHALL load o_product with the final accumulator on the edge entering DONE, and hold it unchanged until the next DONE entry.
REQ-018 SHALL stay in DONE while i_ready=0, with o_valid and o_product stable (backpressure).
REQ-019 SHALL return to IDLE on the edge where state is DONE and i_ready=1; no operand accept occurs on that same edge (o_ready=0 in DONE).
REQ-020 SHALL ignore i_valid, i_op_a and i_op_b outside IDLE.
REQ-021 Baseline latency: o_valid SHALL first be high WIDTH+1 cycles after the accept edge; maximum throughput is one product per WIDTH+2 cycles.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, o_ready=1, o_valid=0, o_product=0, and clear accumulator, A, B and counter.
REQ-023 SHALL abandon any in-flight operation on reset assertion; no o_valid pulse may follow release without a new accept.
REQ-024 SHALL accept operands on the first rising edge after rst_n deasserts if i_valid=1.

Configuration
REQ-025 SHALL compile early termination in only when macro MULT_EARLY_TERM_EN is defined.
REQ-026 With MULT_EARLY_TERM_EN: SHALL go from RUN to DONE after any RUN step whose shifted B equals 0, and from IDLE directly to DONE (o_product=0) when accepted i_op_b=0.
REQ-027 Without MULT_EARLY_TERM_EN: RUN length SHALL be exactly WIDTH cycles for every operand pair, including i_op_b=0.
REQ-028 Product values SHALL be identical with and without the macro; only latency differs.

Verification (WIDTH=8)
REQ-029 Reset, then a=13, b=11, i_ready=1 -> o_valid high 9 cycles after accept (baseline), o_product=143.
REQ-030 a=255, b=255 -> o_product=0xFE01, cout of the adder ignored, no wrap error.
REQ-031 a=7, b=6, i_ready=0 for 5 cycles after o_valid -> o_valid and o_product=42 held stable, o_ready=0; IDLE one cycle after i_ready=1.
REQ-032 Accept a=100, b=200, assert rst_n=0 at RUN step 4 -> o_valid=0, o_product=0, o_ready=1; a new op a=3, b=4 then gives 12.
REQ-033 MULT_EARLY_TERM_EN defined: a=5, b=3 -> 2 RUN cycles, product 15; a=9, b=0 -> o_valid on the cycle after accept, product 0; undefined: both take 8 RUN cycles, same products.
REQ-034 Back-to-back: i_valid held high with 4 operand pairs -> each accepted only in IDLE; 4 correct products in order versus the reference model a*b.
